// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv/pool/relu engine.
// Holds the FSM state enum, width defaults, end marker and saturation helper.
package cnn_pkg;

    localparam int CNN_DATA_W = 8;
    localparam int CNN_ACC_W  = 20;

    localparam logic [15:0] END_MARKER = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_KERN,
        S_RD_DIM,
        S_MAC,
        S_POOL,
        S_WRITE,
        S_DONE
    } state_t;

    // Largest positive value representable in a signed w-bit result.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pool_relu.sv
// Combinational 2x2 max-pool of four signed sums followed by ReLU clamp.
// Ports: s0..s3 signed ACC_W sums in; res DATA_W clamped result out.
module pool_relu
    import cnn_pkg::*;
#(
    parameter int ACC_W  = CNN_ACC_W,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic [ACC_W-1:0]  s0,
    input  logic [ACC_W-1:0]  s1,
    input  logic [ACC_W-1:0]  s2,
    input  logic [ACC_W-1:0]  s3,
    output logic [DATA_W-1:0] res
);

    localparam logic signed [ACC_W-1:0] SAT = ACC_W'(sat_max(DATA_W));

    logic signed [ACC_W-1:0] m01;
    logic signed [ACC_W-1:0] m23;
    logic signed [ACC_W-1:0] mx;

    always_comb begin
        m01 = ($signed(s0) > $signed(s1)) ? $signed(s0) : $signed(s1);
        m23 = ($signed(s2) > $signed(s3)) ? $signed(s2) : $signed(s3);
        mx  = (m01 > m23) ? m01 : m23;
        res = mx[DATA_W-1:0];
        if (mx[ACC_W-1]) begin
            res = '0;
        end else if (mx > SAT) begin
            res = SAT[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv_pool_relu_engine.sv
// KxK convolution + 2x2 max-pool + ReLU over a stream of matrices in SRAM.
// Ports: clk, reset_b (sync, high), dut_run/dut_busy, four SRAM port groups.
module conv_pool_relu_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int K      = 3,
    parameter int ACC_W  = CNN_ACC_W,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              input_sram_write_enable,
    output logic [ADDR_W-1:0] input_sram_write_addresss,
    output logic [15:0]       input_sram_write_data,
    output logic [ADDR_W-1:0] input_sram_read_address,
    input  logic [15:0]       input_sram_read_data,
    output logic              output_sram_write_enable,
    output logic [ADDR_W-1:0] output_sram_write_addresss,
    output logic [15:0]       output_sram_write_data,
    output logic [ADDR_W-1:0] output_sram_read_address,
    input  logic [15:0]       output_sram_read_data,
    output logic              scratchpad_sram_write_enable,
    output logic [ADDR_W-1:0] scratchpad_sram_write_addresss,
    output logic [15:0]       scratchpad_sram_write_data,
    output logic [ADDR_W-1:0] scratchpad_sram_read_address,
    input  logic [15:0]       scratchpad_sram_read_data,
    output logic              weights_sram_write_enable,
    output logic [ADDR_W-1:0] weights_sram_write_addresss,
    output logic [15:0]       weights_sram_write_data,
    output logic [ADDR_W-1:0] weights_sram_read_address,
    input  logic [15:0]       weights_sram_read_data
);

    localparam int KK = K * K;
    localparam int NW = (KK + 1) / 2;
    localparam int TW = $clog2(KK + 1);
    localparam int DW2 = 2 * DATA_W;
    localparam logic [TW-1:0] KM1 = TW'(K - 1);

    state_t state, state_nx;

    logic [DATA_W-1:0] kern [KK];
    logic [TW-1:0]     kw, kidx;
    logic              kv;
    logic              pend;
    logic [15:0]       dim, pmax, pr, pc;
    logic [ADDR_W-1:0] base, span, wptr;
    logic [1:0]        sub, psub;
    logic [TW-1:0]     kr, kc, tap, ptap;
    logic              drain, pv, plo;
    logic [ACC_W-1:0]  acc [4];
    logic [DATA_W-1:0] res, held, pooled;
    logic              have_half;

    logic [31:0]       row, col, idx;
    logic              geo_ok, last_out, issue_k;
    logic [15:0]       p_now;
    logic [ADDR_W-1:0] span_now;
    logic signed [DATA_W-1:0] px, ks;
    logic signed [DW2-1:0]    prod;
    logic [15:0]       rd;
    logic              unused_rd;

    assign rd = input_sram_read_data;
    assign unused_rd = ^{output_sram_read_data, scratchpad_sram_read_data};

    assign input_sram_write_enable        = 1'b0;
    assign input_sram_write_addresss      = '0;
    assign input_sram_write_data          = '0;
    assign weights_sram_write_enable      = 1'b0;
    assign weights_sram_write_addresss    = '0;
    assign weights_sram_write_data        = '0;
    assign scratchpad_sram_write_enable   = 1'b0;
    assign scratchpad_sram_write_addresss = '0;
    assign scratchpad_sram_write_data     = '0;
    assign scratchpad_sram_read_address   = '0;
    assign output_sram_read_address       = '0;

    // Element (row, col) of the current window lives at byte idx after the
    // dimension word; even bytes sit in the high half of a word.
    always_comb begin
        row = 32'(pr) * 32'd2 + 32'(sub[1]) + 32'(kr);
        col = 32'(pc) * 32'd2 + 32'(sub[0]) + 32'(kc);
        idx = row * 32'(dim) + col;
        geo_ok = rd >= 16'(K + 1);
        p_now = geo_ok ? 16'((rd - 16'(K - 1)) >> 1) : 16'd0;
        span_now = ADDR_W'(1)
                 + ADDR_W'((32'(rd) * 32'(rd) + 32'd1) >> 1);
        last_out = (pr == pmax - 16'd1) && (pc == pmax - 16'd1);
        issue_k = kw < TW'(NW);
        px = plo ? $signed(rd[DATA_W-1:0]) : $signed(rd[DW2-1:DATA_W]);
        ks = $signed(kern[ptap]);
        prod = DW2'(px) * DW2'(ks);
    end

    pool_relu #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_pool (
        .s0  (acc[0]),
        .s1  (acc[1]),
        .s2  (acc[2]),
        .s3  (acc[3]),
        .res (pooled)
    );

    always_ff @(posedge clk) begin
        if (reset_b) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        input_sram_read_address    = '0;
        weights_sram_read_address  = '0;
        output_sram_write_enable   = 1'b0;
        output_sram_write_addresss = '0;
        output_sram_write_data     = '0;
        unique case (state)
            S_IDLE: begin
                if (dut_run) state_nx = S_LD_KERN;
            end
            S_LD_KERN: begin
                if (issue_k) weights_sram_read_address = ADDR_W'(kw);
                if (kv && kidx == TW'(NW - 1)) state_nx = S_RD_DIM;
            end
            S_RD_DIM: begin
                input_sram_read_address = base;
                if (pend) begin
                    if (rd == END_MARKER) state_nx = S_DONE;
                    else if (geo_ok)      state_nx = S_MAC;
                end
            end
            S_MAC: begin
                input_sram_read_address = base + ADDR_W'(1)
                                        + ADDR_W'(idx >> 1);
                if (drain) state_nx = S_POOL;
            end
            S_POOL: state_nx = S_WRITE;
            S_WRITE: begin
                if (have_half || last_out) begin
                    output_sram_write_enable   = 1'b1;
                    output_sram_write_addresss = wptr;
                    output_sram_write_data     = have_half
                        ? {held, res} : {res, {DATA_W{1'b0}}};
                end
                state_nx = last_out ? S_RD_DIM : S_MAC;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            dut_busy  <= 1'b0;
            kw        <= '0;
            kidx      <= '0;
            kv        <= 1'b0;
            pend      <= 1'b0;
            dim       <= '0;
            pmax      <= '0;
            pr        <= '0;
            pc        <= '0;
            base      <= '0;
            span      <= '0;
            wptr      <= '0;
            sub       <= '0;
            kr        <= '0;
            kc        <= '0;
            tap       <= '0;
            psub      <= '0;
            ptap      <= '0;
            drain     <= 1'b0;
            pv        <= 1'b0;
            plo       <= 1'b0;
            res       <= '0;
            held      <= '0;
            have_half <= 1'b0;
        end else begin
            dut_busy <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            kv <= 1'b0;
            pv <= 1'b0;
            // Tap 0 of each window restarts its sum.
            if (pv) begin
                acc[psub] <= (ptap == '0 ? '0 : acc[psub])
                           + ACC_W'(prod);
            end
            unique case (state)
                S_IDLE: begin
                    if (dut_run) begin
                        kw        <= '0;
                        base      <= '0;
                        wptr      <= '0;
                        have_half <= 1'b0;
                        pend      <= 1'b0;
                    end
                end
                S_LD_KERN: begin
                    if (issue_k) begin
                        kv   <= 1'b1;
                        kidx <= kw;
                        kw   <= kw + 1'b1;
                    end
                    if (kv) begin
                        for (int i = 0; i < KK; i++) begin
                            if (TW'(i / 2) == kidx) begin
                                kern[i] <= (i % 2 == 0)
                                    ? weights_sram_read_data[DW2-1:DATA_W]
                                    : weights_sram_read_data[DATA_W-1:0];
                            end
                        end
                    end
                end
                S_RD_DIM: begin
                    pend <= !pend;
                    if (pend) begin
                        dim  <= rd;
                        pmax <= p_now;
                        span <= span_now;
                        pr   <= '0;
                        pc   <= '0;
                        if (!geo_ok) base <= base + span_now;
                    end
                end
                S_MAC: begin
                    if (drain) begin
                        drain <= 1'b0;
                    end else begin
                        pv   <= 1'b1;
                        psub <= sub;
                        ptap <= tap;
                        plo  <= idx[0];
                        if (kc == KM1) begin
                            kc <= '0;
                            if (kr == KM1) begin
                                kr  <= '0;
                                tap <= '0;
                                sub <= sub + 2'd1;
                                if (sub == 2'd3) drain <= 1'b1;
                            end else begin
                                kr  <= kr + 1'b1;
                                tap <= tap + 1'b1;
                            end
                        end else begin
                            kc  <= kc + 1'b1;
                            tap <= tap + 1'b1;
                        end
                    end
                end
                S_POOL: res <= pooled;
                S_WRITE: begin
                    if (have_half) begin
                        have_half <= 1'b0;
                        wptr      <= wptr + 1'b1;
                    end else if (last_out) begin
                        wptr <= wptr + 1'b1;
                    end else begin
                        held      <= res;
                        have_half <= 1'b1;
                    end
                    if (last_out) begin
                        base <= base + span;
                        pr   <= '0;
                        pc   <= '0;
                    end else if (pc == pmax - 16'd1) begin
                        pc <= '0;
                        pr <= pr + 16'd1;
                    end else begin
                        pc <= pc + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_relu_engine.sv
// Self-checking bench: SRAM models, directed and random matrices,
// compared against a plain-arithmetic convolution/pool/relu model.
module tb_conv_pool_relu_engine;

    localparam int K      = 3;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset_b = 1'b1;
    logic dut_run = 1'b0;
    logic dut_busy;

    logic              in_we, out_we, sp_we, w_we;
    logic [ADDR_W-1:0] in_wa, out_wa, sp_wa, w_wa;
    logic [15:0]       in_wd, out_wd, sp_wd, w_wd;
    logic [ADDR_W-1:0] in_ra, out_ra, sp_ra, w_ra;
    logic [15:0]       in_rd, w_rd;
    logic [15:0]       out_rd = 16'h0;
    logic [15:0]       sp_rd = 16'h0;

    logic [15:0] in_mem [4096];
    logic [15:0] w_mem [4096];

    logic [11:0] wa_log [$];
    logic [15:0] wd_log [$];
    logic [11:0] exp_a [$];
    logic [15:0] exp_d [$];

    int n_vec = 0;
    int n_err = 0;
    int wp = 0;

    always #5 clk = ~clk;

    conv_pool_relu_engine #(
        .DATA_W (8),
        .K      (K),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                            (clk),
        .reset_b                        (reset_b),
        .dut_run                        (dut_run),
        .dut_busy                       (dut_busy),
        .input_sram_write_enable        (in_we),
        .input_sram_write_addresss      (in_wa),
        .input_sram_write_data          (in_wd),
        .input_sram_read_address        (in_ra),
        .input_sram_read_data           (in_rd),
        .output_sram_write_enable       (out_we),
        .output_sram_write_addresss     (out_wa),
        .output_sram_write_data         (out_wd),
        .output_sram_read_address       (out_ra),
        .output_sram_read_data          (out_rd),
        .scratchpad_sram_write_enable   (sp_we),
        .scratchpad_sram_write_addresss (sp_wa),
        .scratchpad_sram_write_data     (sp_wd),
        .scratchpad_sram_read_address   (sp_ra),
        .scratchpad_sram_read_data      (sp_rd),
        .weights_sram_write_enable      (w_we),
        .weights_sram_write_addresss    (w_wa),
        .weights_sram_write_data        (w_wd),
        .weights_sram_read_address      (w_ra),
        .weights_sram_read_data         (w_rd)
    );

    always @(posedge clk) begin
        in_rd <= in_mem[in_ra];
        w_rd  <= w_mem[w_ra];
    end

    always @(negedge clk) begin
        if (out_we) begin
            wa_log.push_back(out_wa);
            wd_log.push_back(out_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] logd(input int i);
        return (wd_log.size() > i) ? wd_log[i] : 16'hDEAD;
    endfunction

    function automatic logic [15:0] loga(input int i);
        return (wa_log.size() > i) ? 16'(wa_log[i]) : 16'hDEAD;
    endfunction

    function automatic int elem(input int b, input int n,
                                input int r, input int c);
        int i;
        logic [15:0] w;
        logic [7:0] v;
        i = r * n + c;
        w = in_mem[b + 1 + i / 2];
        v = (i % 2 == 1) ? w[7:0] : w[15:8];
        return int'($signed(v));
    endfunction

    function automatic int tapv(input int t);
        logic [15:0] w;
        logic [7:0] v;
        w = w_mem[t / 2];
        v = (t % 2 == 1) ? w[7:0] : w[15:8];
        return int'($signed(v));
    endfunction

    function automatic int conv(input int b, input int n,
                                input int r, input int c);
        int s;
        logic [ACC_W-1:0] wr;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += elem(b, n, r + i, c + j) * tapv(i * K + j);
        wr = ACC_W'(s);
        return int'($signed(wr));
    endfunction

    function automatic logic [7:0] relu(input int v);
        if (v < 0) return 8'd0;
        if (v > 127) return 8'd127;
        return 8'(v);
    endfunction

    task automatic build_expected();
        int b;
        int oa;
        b = 0;
        oa = 0;
        exp_a.delete();
        exp_d.delete();
        for (int m = 0; m < 64; m++) begin
            int n;
            int p;
            logic [7:0] rs [$];
            if (in_mem[b] == 16'hFFFF) break;
            n = int'(in_mem[b]);
            p = (n >= K + 1) ? (n - K + 1) / 2 : 0;
            rs.delete();
            for (int r = 0; r < p; r++) begin
                for (int c = 0; c < p; c++) begin
                    int best;
                    best = -(1 << 30);
                    for (int q = 0; q < 4; q++) begin
                        int s;
                        s = conv(b, n, 2 * r + q / 2, 2 * c + q % 2);
                        if (s > best) best = s;
                    end
                    rs.push_back(relu(best));
                end
            end
            for (int i = 0; i < rs.size(); i += 2) begin
                exp_a.push_back(12'(oa));
                exp_d.push_back({rs[i],
                                 (i + 1 < rs.size()) ? rs[i + 1] : 8'h00});
                oa++;
            end
            b += 1 + (n * n + 1) / 2;
        end
    endtask

    task automatic put_mat(input int n, input int mode);
        int nw;
        nw = (n * n + 1) / 2;
        in_mem[wp] = 16'(n);
        for (int w = 0; w < nw; w++) in_mem[wp + 1 + w] = 16'h0;
        for (int i = 0; i < n * n; i++) begin
            logic [7:0] v;
            case (mode)
                0:       v = 8'(i + 1);
                1:       v = 8'd127;
                2:       v = 8'(i);
                default: v = 8'($urandom_range(0, 255));
            endcase
            if (i % 2 == 0) in_mem[wp + 1 + i / 2][15:8] = v;
            else            in_mem[wp + 1 + i / 2][7:0]  = v;
        end
        wp += 1 + nw;
    endtask

    task automatic set_kern(input int mode);
        for (int w = 0; w < (K * K + 1) / 2; w++) w_mem[w] = 16'h0;
        for (int t = 0; t < K * K; t++) begin
            logic [7:0] v;
            case (mode)
                0:       v = 8'd1;
                1:       v = 8'hFF;
                2:       v = 8'd127;
                3:       v = (t == (K * K) / 2) ? 8'd1 : 8'd0;
                default: v = 8'($urandom_range(0, 255));
            endcase
            if (t % 2 == 0) w_mem[t / 2][15:8] = v;
            else            w_mem[t / 2][7:0]  = v;
        end
    endtask

    task automatic start_job(input string tag);
        in_mem[wp] = 16'hFFFF;
        build_expected();
        wa_log.delete();
        wd_log.delete();
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        chk({tag, "_busy_rise"}, 32'(dut_busy), 32'd1);
    endtask

    task automatic run_job(input string tag);
        int t;
        start_job(tag);
        t = 0;
        while (dut_busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_busy_fall"}, 32'(dut_busy), 32'd0);
        repeat (5) @(negedge clk);
        chk({tag, "_nwr"}, 32'(wa_log.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            chk({tag, "_wa"}, 32'(loga(i)), 32'(exp_a[i]));
            chk({tag, "_wd"}, 32'(logd(i)), 32'(exp_d[i]));
        end
        wp = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(dut_busy), 32'd0);
        chk("rst_owe", 32'(out_we), 32'd0);
        chk("rst_owa", 32'(out_wa), 32'd0);
        chk("rst_owd", 32'(out_wd), 32'd0);
        chk("rst_iwe", 32'({in_we, w_we, sp_we}), 32'd0);
        chk("rst_sra", 32'(sp_ra), 32'd0);

        set_kern(0); put_mat(4, 0);
        run_job("t1");
        chk("t1_a0", 32'(loga(0)), 32'h0);
        chk("t1_d0", 32'(logd(0)), 32'h6300);

        set_kern(1); put_mat(4, 0);
        run_job("t2");
        chk("t2_d0", 32'(logd(0)), 32'h0000);

        set_kern(2); put_mat(4, 1);
        run_job("t3");
        chk("t3_d0", 32'(logd(0)), 32'h7F00);

        set_kern(3); put_mat(6, 2);
        run_job("t4");
        chk("t4_d0", 32'(logd(0)), 32'h0E10);
        chk("t4_d1", 32'(logd(1)), 32'h1A1C);

        set_kern(0); put_mat(4, 0); put_mat(4, 0);
        run_job("t5");
        chk("t5_a1", 32'(loga(1)), 32'h1);
        chk("t5_lo0", 32'(logd(0) & 16'hFF), 32'h0);
        chk("t5_lo1", 32'(logd(1) & 16'hFF), 32'h0);

        set_kern(0); put_mat(3, 3); put_mat(5, 3);
        run_job("t6");

        for (int j = 0; j < 10; j++) begin
            int nm;
            set_kern(4);
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) put_mat($urandom_range(2, 9), 3);
            run_job("rnd");
        end

        set_kern(0); put_mat(4, 3); put_mat(4, 3);
        start_job("t7");
        t = 0;
        while (wa_log.size() < 1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("t7_first", 32'(wa_log.size()), 32'd1);
        repeat (10) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        chk("t7_rst_busy", 32'(dut_busy), 32'd0);
        chk("t7_rst_we", 32'(out_we), 32'd0);
        repeat (100) @(negedge clk);
        chk("t7_nomore", 32'(wa_log.size()), 32'd1);
        chk("t7_idle", 32'(dut_busy), 32'd0);
        wp = 0;

        set_kern(4); put_mat(5, 3); put_mat(4, 3);
        run_job("t8");
        chk("t8_a0", 32'(loga(0)), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
